softex_tcdm_arbiter: RTL and testbench

// - N-channel TCDM arbiter for the softex streamer; one module replaces the 2-input mux + FIFO + r_id filter chains.
// - Merges NB_CH hci-style initiator channels (load/store sources and sinks) onto one TCDM port.
// - Returns in-order read responses to the originating channel through an outstanding-ID FIFO.
// - Adds a runtime choice of round-robin or fixed-priority arbitration, and a configurable outstanding depth.

---
 rtl/softex_tcdm_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_softex_tcdm_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softex_tcdm_arbiter.sv
// rtl/softex_tcdm_arbiter.sv - N-channel TCDM arbiter with locked grants and in-order read-ID return
// Optional per-channel grant counters are built when SOFTEX_ARB_PERF_EN is defined.
module softex_tcdm_arbiter #(
    parameter  int unsigned NB_CH           = 4,
    parameter  int unsigned DATA_WIDTH      = 64,
    parameter  int unsigned ADDR_WIDTH      = 32,
    parameter  int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CW              = $clog2(NB_CH),
    localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned BW              = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          arb_mode_i,
    input  logic [CW-1:0]                 prio_ch_i,
    input  logic [NB_CH-1:0]              in_req_i,
    output logic [NB_CH-1:0]              in_gnt_o,
    input  logic [NB_CH*ADDR_WIDTH-1:0]   in_add_i,
    input  logic [NB_CH-1:0]              in_wen_i,
    input  logic [NB_CH*BW-1:0]           in_be_i,
    input  logic [NB_CH*DATA_WIDTH-1:0]   in_data_i,
    output logic [NB_CH-1:0]              in_r_valid_o,
    output logic [DATA_WIDTH-1:0]         in_r_data_o,
    output logic                          out_req_o,
    input  logic                          out_gnt_i,
    output logic [ADDR_WIDTH-1:0]         out_add_o,
    output logic                          out_wen_o,
    output logic [BW-1:0]                 out_be_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    input  logic                          out_r_valid_i,
    input  logic [DATA_WIDTH-1:0]         out_r_data_i,
    output logic [OW-1:0]                 outstanding_o,
    output logic                          err_o,
    output logic [NB_CH*32-1:0]           perf_gnt_cnt_o
);

    localparam int unsigned   PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] LAST_CH  = CW'(NB_CH - 1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);

    logic [CW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [CW-1:0] lock_ch_q, lock_ch_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [CW-1:0] id_mem [MAX_OUTSTANDING];

    logic [NB_CH-1:0] elig;
    logic [CW-1:0]    start;
    logic [CW-1:0]    win;
    logic             any;
    logic             hs;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    int unsigned      idx;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // Reads wait on the registered full flag so eligibility never depends on this cycle's response.
    always_comb begin
        elig = '0;
        for (int unsigned c = 0; c < NB_CH; c++) begin
            elig[c] = in_req_i[c] & (~in_wen_i[c] | ~full);
        end
    end

    always_comb begin
        start = ptr_q;
        if (arb_mode_i) begin
            start = (32'(prio_ch_i) < NB_CH) ? prio_ch_i : '0;
        end
    end

    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        if (lock_q && in_req_i[lock_ch_q]) begin
            win = lock_ch_q;
            any = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NB_CH; i++) begin
                idx = 32'(start) + i;
                if (idx >= NB_CH) begin
                    idx = idx - NB_CH;
                end
                if (!any && elig[CW'(idx)]) begin
                    win = CW'(idx);
                    any = 1'b1;
                end
            end
        end
    end

    assign hs        = any & out_gnt_i;
    assign out_req_o = any;
    assign out_add_o = in_add_i[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign out_wen_o = in_wen_i[win];
    assign out_be_o  = in_be_i[win*BW +: BW];
    assign out_data_o = in_data_i[win*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        in_gnt_o = '0;
        if (hs) begin
            in_gnt_o[win] = 1'b1;
        end
    end

    // A response arriving while full frees the slot the same cycle's push would need.
    assign pop  = out_r_valid_i & ~empty;
    assign push = hs & out_wen_o & (~full | pop);

    always_comb begin
        in_r_valid_o = '0;
        if (pop) begin
            in_r_valid_o[id_mem[rd_q]] = 1'b1;
        end
    end

    assign in_r_data_o   = out_r_data_i;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

    always_comb begin
        ptr_d     = ptr_q;
        lock_d    = any & ~out_gnt_i;
        lock_ch_d = win;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (hs && !arb_mode_i) begin
            ptr_d = (win == LAST_CH) ? '0 : win + 1'b1;
        end
        if (push) begin
            wr_d = (wr_q == LAST_SLOT) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == LAST_SLOT) ? '0 : rd_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (out_r_valid_i && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else if (clear_i) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            id_mem[wr_q] <= win;
        end
    end

`ifdef SOFTEX_ARB_PERF_EN
    logic [31:0] perf_q [NB_CH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned c = 0; c < NB_CH; c++) begin
                perf_q[c] <= '0;
            end
        end else if (clear_i) begin
            for (int unsigned c = 0; c < NB_CH; c++) begin
                perf_q[c] <= '0;
            end
        end else if (hs) begin
            perf_q[win] <= perf_q[win] + 32'd1;
        end
    end

    always_comb begin
        perf_gnt_cnt_o = '0;
        for (int unsigned c = 0; c < NB_CH; c++) begin
            perf_gnt_cnt_o[c*32 +: 32] = perf_q[c];
        end
    end
`else
    assign perf_gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_softex_tcdm_arbiter.sv
// tb/tb_softex_tcdm_arbiter.sv - directed and random checks of softex_tcdm_arbiter against a queue model
module tb_softex_tcdm_arbiter;
    localparam int NB_CH = 4;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int MO    = 2;
    localparam int CW    = 2;
    localparam int OW    = 2;
    localparam int BW    = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  clear = 1'b0;
    logic                  arb_mode = 1'b0;
    logic [CW-1:0]         prio_ch = '0;
    logic [NB_CH-1:0]      in_req = '0;
    logic [NB_CH-1:0]      in_gnt;
    logic [NB_CH*AW-1:0]   in_add = '0;
    logic [NB_CH-1:0]      in_wen = '0;
    logic [NB_CH*BW-1:0]   in_be = '0;
    logic [NB_CH*DW-1:0]   in_data = '0;
    logic [NB_CH-1:0]      in_r_valid;
    logic [DW-1:0]         in_r_data;
    logic                  out_req;
    logic                  out_gnt = 1'b0;
    logic [AW-1:0]         out_add;
    logic                  out_wen;
    logic [BW-1:0]         out_be;
    logic [DW-1:0]         out_data;
    logic                  out_r_valid = 1'b0;
    logic [DW-1:0]         out_r_data = '0;
    logic [OW-1:0]         outstanding;
    logic                  err;
    logic [NB_CH*32-1:0]   perf;

    softex_tcdm_arbiter #(
        .NB_CH(NB_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .arb_mode_i(arb_mode), .prio_ch_i(prio_ch),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
        .in_be_i(in_be), .in_data_i(in_data), .in_r_valid_o(in_r_valid), .in_r_data_o(in_r_data),
        .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_wen_o(out_wen),
        .out_be_o(out_be), .out_data_o(out_data), .out_r_valid_i(out_r_valid),
        .out_r_data_i(out_r_data), .outstanding_o(outstanding), .err_o(err),
        .perf_gnt_cnt_o(perf)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int          mptr = 0;
    bit          mlock = 0;
    int          mlock_ch = 0;
    int          fifo[$];
    bit          merr = 0;
    int unsigned mperf[NB_CH];
    int          exp_win;
    bit          exp_req;

    logic             s_req, s_err;
    logic [NB_CH-1:0] s_gnt, s_rv;
    logic [AW-1:0]    s_add;
    logic [OW-1:0]    s_out;
    logic [127:0]     s_perf;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit eligible(input int c);
        return in_req[c] && (!in_wen[c] || fifo.size() < MO);
    endfunction

    task automatic model_select();
        int start;
        exp_req = 0;
        exp_win = 0;
        if (mlock && in_req[mlock_ch]) begin
            exp_req = 1;
            exp_win = mlock_ch;
            return;
        end
        start = arb_mode ? ((int'(prio_ch) < NB_CH) ? int'(prio_ch) : 0) : mptr;
        for (int i = 0; i < NB_CH; i++) begin
            int c;
            c = (start + i) % NB_CH;
            if (eligible(c)) begin
                exp_req = 1;
                exp_win = c;
                break;
            end
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic [NB_CH-1:0] eg, erv;
        logic [127:0]     ep;
        bit               hs;
        @(negedge clk);
        model_select();
        hs = exp_req && out_gnt;
        eg = '0;
        if (hs) eg[exp_win] = 1'b1;
        erv = '0;
        if (out_r_valid && fifo.size() > 0) erv[fifo[0]] = 1'b1;
        ep = '0;
`ifdef SOFTEX_ARB_PERF_EN
        for (int c = 0; c < NB_CH; c++) ep[c*32 +: 32] = mperf[c];
`endif
        chk("out_req", out_req, exp_req);
        chk("in_gnt", in_gnt, eg);
        if (exp_req) begin
            chk("out_add", out_add, in_add[exp_win*AW +: AW]);
            chk("out_wen", out_wen, in_wen[exp_win]);
            chk("out_be", out_be, in_be[exp_win*BW +: BW]);
            chk("out_data", out_data, in_data[exp_win*DW +: DW]);
        end
        chk("in_r_valid", in_r_valid, erv);
        chk("in_r_data", in_r_data, out_r_data);
        chk("outstanding", outstanding, fifo.size());
        chk("err", err, merr);
        chk("perf", perf, ep);
        s_req = out_req; s_gnt = in_gnt; s_rv = in_r_valid; s_add = out_add;
        s_err = err; s_out = outstanding; s_perf = perf;
        @(posedge clk);
        if (clear) begin
            mptr = 0; mlock = 0; fifo.delete(); merr = 0;
            for (int c = 0; c < NB_CH; c++) mperf[c] = 0;
        end else begin
            if (out_r_valid) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                else merr = 1;
            end
            if (hs && in_wen[exp_win]) fifo.push_back(exp_win);
            if (hs && !arb_mode) mptr = (exp_win + 1) % NB_CH;
            if (hs) mperf[exp_win]++;
            mlock = exp_req && !out_gnt;
            mlock_ch = exp_win;
        end
        #1;
    endtask

    task automatic rand_fields();
        for (int c = 0; c < NB_CH; c++) begin
            in_add[c*AW +: AW] = $urandom;
            in_be[c*BW +: BW] = BW'($urandom);
            in_data[c*DW +: DW] = {$urandom, $urandom};
        end
        out_r_data = {$urandom, $urandom};
    endtask

    task automatic idle_inputs();
        in_req = '0; in_wen = '0; out_gnt = 1'b0; out_r_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        logic [127:0] perf_exp;
        for (int c = 0; c < NB_CH; c++) mperf[c] = 0;

        @(negedge clk);
        chk("rst_out_req", out_req, 1'b0);
        chk("rst_in_gnt", in_gnt, 4'b0);
        chk("rst_in_r_valid", in_r_valid, 4'b0);
        chk("rst_outstanding", outstanding, 2'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_perf", perf, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin fairness with all four channels reading.
        for (int k = 0; k < 5; k++) begin
            rand_fields();
            in_req = 4'hF; in_wen = 4'hF; out_gnt = 1'b1; out_r_valid = (k > 0);
            cycle();
            chk("rr_gnt", s_gnt, 4'b1 << (k % 4));
            if (k > 0) chk("rr_rvalid", s_rv, 4'b1 << ((k - 1) % 4));
        end
        idle_inputs();
        out_r_valid = 1'b1;
        cycle();
        chk("rr_rvalid_last", s_rv, 4'b0001);

        // Lock on ch2 while ch0 arrives.
        do_clear();
        rand_fields();
        for (int k = 1; k <= 4; k++) begin
            in_req = (k >= 2) ? 4'b0101 : 4'b0100;
            in_wen = 4'b0000;
            out_gnt = (k == 4);
            cycle();
            chk("lock_add", s_add, in_add[2*AW +: AW]);
            if (k == 4) chk("lock_gnt", s_gnt, 4'b0100);
        end
        in_req = 4'b0001;
        cycle();
        chk("lock_after", s_gnt, 4'b0001);

        // Fixed priority on ch3.
        do_clear();
        arb_mode = 1'b1; prio_ch = 2'd3;
        for (int k = 0; k < 3; k++) begin
            rand_fields();
            in_req = 4'b1010; in_wen = 4'b0000; out_gnt = 1'b1;
            cycle();
            chk("fixed_gnt3", s_gnt, 4'b1000);
        end
        in_req = 4'b0010;
        cycle();
        chk("fixed_gnt1", s_gnt, 4'b0010);
        arb_mode = 1'b0;

        // Backpressure from the outstanding-ID FIFO.
        do_clear();
        rand_fields();
        in_req = 4'b0101; in_wen = 4'b0101; out_gnt = 1'b1;
        cycle();
        chk("bp_gnt0", s_gnt, 4'b0001);
        cycle();
        chk("bp_gnt2", s_gnt, 4'b0100);
        in_req = 4'b0111;
        cycle();
        chk("bp_out2", s_out, 2'd2);
        chk("bp_write", s_gnt, 4'b0010);
        in_req = 4'b0101;
        cycle();
        chk("bp_blocked", s_req, 1'b0);
        out_r_valid = 1'b1;
        cycle();
        chk("bp_rv", s_rv, 4'b0001);
        out_r_valid = 1'b0;
        cycle();
        chk("bp_regrant", s_gnt, 4'b0100);
        idle_inputs();
        out_r_valid = 1'b1;
        cycle();
        cycle();
        out_r_valid = 1'b0;

        // Response with no read in flight.
        do_clear();
        out_r_valid = 1'b1;
        cycle();
        chk("err_rv", s_rv, 4'b0000);
        out_r_valid = 1'b0;
        cycle();
        chk("err_set", s_err, 1'b1);
        cycle();
        chk("err_sticky", s_err, 1'b1);
        do_clear();
        cycle();
        chk("err_clear", s_err, 1'b0);

        // Grant counters.
        do_clear();
        out_gnt = 1'b1; in_wen = 4'b0000;
        in_req = 4'b0001;
        repeat (5) cycle();
        in_req = 4'b1000;
        repeat (2) cycle();
        idle_inputs();
        cycle();
`ifdef SOFTEX_ARB_PERF_EN
        perf_exp = {32'd2, 32'd0, 32'd0, 32'd5};
`else
        perf_exp = '0;
`endif
        chk("perf_cnt", s_perf, perf_exp);

        // Random traffic against the model.
        do_clear();
        for (int k = 0; k < 600; k++) begin
            rand_fields();
            in_req  = NB_CH'($urandom);
            in_wen  = NB_CH'($urandom);
            out_gnt = ($urandom_range(0, 3) != 0);
            out_r_valid = (fifo.size() > 0) ? 1'($urandom) : ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) arb_mode = ~arb_mode;
            if ($urandom_range(0, 7) == 0) prio_ch = CW'($urandom);
            clear = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
